// File: rtl/add_nibble_seq.sv
// add_nibble_seq: multi-cycle WIDTH-bit adder reusing one 4-bit ripple adder, one nibble per cycle
module add_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[4];
endmodule

module add_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  if (WIDTH % 4 != 0 || WIDTH < 4) begin : g_bad_width
    $error("add_nibble_seq: WIDTH must be a multiple of 4 and at least 4");
  end
  logic [1:0] state;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic carry;
  logic [IW-1:0] idx;
  logic [IW+1:0] sh;
  logic [3:0] a_nib, b_nib, nsum;
  logic ncarry, last;
  assign sh = {idx, 2'b00};
  assign a_nib = 4'(a_reg >> sh);
  assign b_nib = 4'(b_reg >> sh);
  assign last = idx == IW'(NIB - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  add_4 u_add (.a(a_nib), .b(b_nib), .ci(carry), .s(nsum), .co(ncarry));
  // accept operands, step one nibble per RUN cycle, hold the result until the consumer takes it
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx <= '0;
      s <= '0;
      co <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_reg <= a;
        b_reg <= b;
        carry <= ci;
        idx <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      s <= (s & ~(WIDTH'(4'hf) << sh)) | (WIDTH'(nsum) << sh);
      carry <= ncarry;
      if (last) begin
        co <= ncarry;
        ovf <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (nsum[3] != a_reg[WIDTH-1]);
        state <= DONE;
      end else idx <= idx + IW'(1);
    end else if (out_ready) state <= IDLE;
endmodule

// File: tb/tb_add_nibble_seq.sv
// tb_add_nibble_seq: scoreboard bench for add_nibble_seq at WIDTH 16, 4 and 32
module tb_add_nibble_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0, bad = 0;
  logic rst_n, in_valid, in_ready, ci, out_valid, out_ready, co, ovf, busy;
  logic [15:0] a, b, s;
  logic [17:0] exp_q[$];

  add_nibble_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .ci(ci),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co), .ovf(ovf), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // result monitor: every output handshake pops the oldest expected {ovf,co,s}
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h want none", {ovf, co, s});
      end else chk("result", {ovf, co, s}, exp_q.pop_front());
    end

  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic [17:0] e);
    int n;
    a = ta;
    b = tb;
    ci = tc;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
    end else exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = 16'hdead;
    b = 16'hbeef;
    ci = ~tc;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_w
    localparam int W = g == 0 ? 4 : 32;
    localparam int N = W / 4;
    logic rn, iv, ir, gc, ov, gco, govf, gbusy, done;
    logic [W-1:0] ga, gbv, gs;
    logic [W+1:0] q[$];
    add_nibble_seq #(.WIDTH(W)) u (
      .clk(clk), .rst_n(rn), .in_valid(iv), .in_ready(ir), .a(ga), .b(gbv), .ci(gc),
      .out_valid(ov), .out_ready(1'b1), .s(gs), .co(gco), .ovf(govf), .busy(gbusy)
    );
    always @(negedge clk)
      if (rn && ov) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL w%0d_unexpected_out: got %0h want none", W, {govf, gco, gs});
        end else chk($sformatf("w%0d_result", W), 64'({govf, gco, gs}), 64'(q.pop_front()));
      end
    initial begin
      int n, last;
      logic [W:0] sum;
      done = 1'b0;
      rn = 1'b0;
      iv = 1'b0;
      ga = '0;
      gbv = '0;
      gc = 1'b0;
      last = 0;
      repeat (3) @(posedge clk);
      #1 rn = 1'b1;
      for (int i = 0; i < 20; i++) begin
        ga = i == 0 ? '1 : W'($urandom);
        gbv = i == 0 ? '0 : W'($urandom);
        gc = i == 0 ? 1'b1 : 1'($urandom);
        iv = 1'b1;
        sum = {1'b0, ga} + {1'b0, gbv} + (W+1)'(gc);
        n = 0;
        while (!ir && n < 40) begin
          @(posedge clk);
          #1 n++;
        end
        if (n >= 40) begin
          total++;
          bad++;
          $display("FAIL w%0d_accept_timeout: got in_ready=0 want 1", W);
        end else begin
          q.push_back({(ga[W-1] == gbv[W-1]) && (sum[W-1] != ga[W-1]), sum});
          if (i > 0) chk($sformatf("w%0d_spacing", W), 64'(cyc - last), 64'(N + 2));
          last = cyc;
        end
        @(posedge clk);
        #1;
      end
      iv = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 100) begin
        @(posedge clk);
        #1 n++;
      end
      chk($sformatf("w%0d_drain", W), 64'(q.size()), 0);
      done = 1'b1;
    end
  end

  initial begin
    int n, pa;
    logic [16:0] sum;
    logic [15:0] ra, rb;
    logic rc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    ci = 1'b0;
    pa = 0;
    repeat (3) @(posedge clk);
    #1 chk("reset_state", {in_ready, busy, out_valid, ovf, co, s}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("idle_ready", {in_ready, busy}, 2'b10);
    send(16'h1234, 16'h4321, 1'b0, {2'b00, 16'h5555});
    chk("run_busy", {in_ready, busy, out_valid}, 3'b010);
    wait_out(n);
    chk("latency", n, 4);
    send(16'hffff, 16'h0001, 1'b0, {2'b01, 16'h0000});
    wait_out(n);
    chk("latency_ripple", n, 4);
    send(16'hffff, 16'h0000, 1'b1, {2'b01, 16'h0000});
    send(16'h7fff, 16'h0001, 1'b0, {2'b10, 16'h8000});
    send(16'h8000, 16'h8000, 1'b0, {2'b11, 16'h0000});
    send(16'hffff, 16'hffff, 1'b0, {2'b01, 16'hfffe});
    send(16'h7fff, 16'h0000, 1'b1, {2'b10, 16'h8000});
    wait_out(n);
    @(posedge clk);
    #1 chk("q_empty_directed", exp_q.size(), 0);
    out_ready = 1'b0;
    send(16'h0102, 16'h0304, 1'b0, {2'b00, 16'h0406});
    wait_out(n);
    in_valid = 1'b1;
    a = 16'haaaa;
    b = 16'h5555;
    ci = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1 chk("backpressure_hold", {out_valid, in_ready, busy, ovf, co, s}, {3'b101, 2'b00, 16'h0406});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("after_handshake", {out_valid, in_ready, busy, s}, {3'b010, 16'h0406});
    chk("q_after_bp", exp_q.size(), 0);
    send(16'haaaa, 16'h5555, 1'b0, {2'b00, 16'hffff});
    wait_out(n);
    chk("latency_after_bp", n, 4);
    send(16'h1111, 16'h2222, 1'b0, {2'b00, 16'h3333});
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 chk("mid_reset", {in_ready, busy, out_valid, ovf, co, s}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
    rst_n = 1'b1;
    exp_q.delete();
    repeat (6) begin
      @(posedge clk);
      #1 chk("no_out_after_reset", {out_valid, in_ready}, 2'b01);
    end
    send(16'h0f0f, 16'h0101, 1'b1, {2'b00, 16'h1011});
    wait_out(n);
    chk("latency_after_reset", n, 4);
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      sum = {1'b0, ra} + {1'b0, rb} + 17'(rc);
      send(ra, rb, rc, {(ra[15] == rb[15]) && (sum[15] != ra[15]), sum});
      if (i > 0) chk("stream_spacing", 64'(cyc - pa), 6);
      pa = cyc;
    end
    n = 0;
    while ((exp_q.size() != 0 || !g_w[0].done || !g_w[1].done) && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain", {exp_q.size(), g_w[0].done, g_w[1].done}, {32'd0, 2'b11});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/add_nibble_seq.md
Name: add_nibble_seq

Overview:
- Multi-cycle sequencer that adds two WIDTH-bit operands by reusing one `add_4` 4-bit ripple adder instance, one nibble per cycle, from LSB to MSB.
- Carry is registered between nibbles.
- Sits between a producer and a consumer, with valid/ready handshakes on both sides.
- Trades latency for area where a full-width adder is not justified.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- NIB, WIDTH/4, derived number of nibble steps; not user-overridable.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands a, b, ci are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in to nibble 0.
- out_valid  output  1  result s/co/ovf is valid.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  sum.
- co  output  1  carry out of the MSB nibble.
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high when not in IDLE.

Behaviour:
- Reset: rst_n sampled low at a rising edge forces state IDLE. All of the following go to 0: captured operands, carry register, nibble index, s, co, ovf, out_valid, busy. in_ready reads 1 in the first cycle after reset deasserts. Reset during RUN or DONE discards the operation; nothing is emitted.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On in_valid && in_ready at an edge: capture a, b into operand registers; carry<=ci; idx<=0; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Every cycle, `add_4` is driven with a_reg[4*idx+:4], b_reg[4*idx+:4] and carry.
  - At the edge: s[4*idx+:4] <= nibble sum; carry <= nibble carry-out; idx <= idx+1.
  - When idx==NIB-1, at the edge: co <= nibble carry-out; ovf <= (a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (final sum MSB != a_reg[WIDTH-1]); go to DONE.
  - idx never wraps past NIB-1.
- DONE:
  - out_valid=1, busy=1, in_ready=0.
  - s, co, ovf are held stable until out_valid && out_ready at an edge, then go to IDLE.
  - in_valid is ignored here; there is no overlap of a new acceptance with a pending result.
- Latency: out_valid rises exactly NIB cycles after the acceptance edge (16-bit: 4 cycles).
- Throughput: with out_ready tied high, one operation per NIB+2 cycles:
  - 1 cycle IDLE accept,
  - NIB cycles RUN,
  - 1 cycle DONE.
- Input-side rules:
  - Input operands are sampled only at the acceptance edge.
  - a, b, ci may change freely afterwards.
- Output-side rules:
  - After the output handshake, s, co, ovf retain the last result (out_valid=0); consumers qualify them with out_valid only.
  - out_valid does not drop without a handshake except on reset.
- Arithmetic: result is {co, s} = a + b + ci, exact modulo 2^(WIDTH+1). ovf is valid for both ci values.
- Degenerate WIDTH=4 (NIB=1):
  - RUN lasts one cycle.
  - idx register is at least 1 bit wide.
  - Behaviour is otherwise identical.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.
  - in_ready and out_valid are decoded from state only.

Test Plan:
- WIDTH=16; a=0x1234, b=0x4321, ci=0, accepted at edge E -> out_valid=1 after edge E+4; s=0x5555, co=0, ovf=0.
- a=0xFFFF, b=0x0001, ci=0 (carry ripples through all nibbles) -> s=0x0000, co=1, ovf=0. Repeat with a=0xFFFF, b=0x0000, ci=1 -> same result.
- Signed overflow cases:
  - a=0x7FFF, b=0x0001 -> s=0x8000, co=0, ovf=1.
  - a=0x8000, b=0x8000 -> s=0x0000, co=1, ovf=1.
  - a=0xFFFF, b=0xFFFF -> s=0xFFFE, co=1, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> s/co/ovf stable; in_ready=0; no second acceptance. On out_ready=1 -> one handshake, IDLE next cycle, then new operands accepted.
- Reset mid-operation: assert rst_n=0 for one edge when idx=2 -> next cycle state IDLE; outputs 0; in_ready=1; no out_valid pulse. A subsequent operation computes correctly.
- Streaming: 20 random operand sets with in_valid and out_ready held high, checked against a+b+ci reference model -> all results correct in order; 6-cycle spacing between acceptances. Rerun with WIDTH=4 and WIDTH=32.
